rf_writeback_queue: RTL and testbench

- Writer side of the register-file write port: collects completed results from the ALU and load paths and drives `DstReg`/`WriteReg`/`DstData`/`llb`/`lhb` into the register file.
- The register file has one write port but two producers can finish in the same cycle, so results are buffered in a small in-order FIFO and drained at one write per cycle.
- Also reports pending-write (RAW) hazards on the two decode read registers so decode can stall until the write has landed.

---
 rtl/rf_writeback_queue_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 71 +++++++
 rtl/rf_writeback_queue.sv | 93 +++++++++
 tb/tb_rf_writeback_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_writeback_queue_pkg.sv
// Shared types and constants for the register-file writeback path.
// The byte-mode encoding is the {llb, lhb} pair the register file decodes.
package rf_writeback_queue_pkg;

    localparam logic [3:0] REG_ZERO = 4'd0;

    typedef enum logic [1:0] {
        BYTE_WORD = 2'b00,
        BYTE_HIGH = 2'b01,
        BYTE_LOW  = 2'b10
    } byteMode_e;

    typedef struct packed {
        logic [3:0]  dst;
        logic [15:0] data;
        logic        llb;
        logic        lhb;
    } wbEntry_t;

    // LLB takes priority over LHB, matching the register-file byte select.
    function automatic byteMode_e byteModeOf(input logic isLlb, input logic isLhb);
        if (isLlb) begin
            return BYTE_LOW;
        end else if (isLhb) begin
            return BYTE_HIGH;
        end
        return BYTE_WORD;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback FIFO: up to two pushes and one pop per edge, with count.
// Exposes per-slot occupancy and destinations so the top can compare hazards.
module wb_fifo
    import rf_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTRW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   pushA,
    input  wbEntry_t               entryA,
    input  logic                   pushB,
    input  wbEntry_t               entryB,
    input  logic                   pop,
    output wbEntry_t               headEntry,
    output logic [PTRW:0]          count,
    output logic [DEPTH-1:0]       slotValid,
    output logic [DEPTH-1:0][3:0]  slotDst
);

    localparam int unsigned CNTW = PTRW + 1;

    wbEntry_t        mem [DEPTH];
    logic [PTRW-1:0] headPtr;
    logic [PTRW-1:0] tailPtr;
    logic [PTRW-1:0] tailPlusOne;
    logic [1:0]      pushCount;
    logic            popEff;

    assign tailPlusOne = tailPtr + PTRW'(1);
    assign pushCount   = {1'b0, pushA} + {1'b0, pushB};
    assign popEff      = pop && (count != '0);
    assign headEntry   = mem[headPtr];

    // Entry A always lands first so a dual push keeps program order.
    always_ff @(posedge clk) begin
        if (pushA) begin
            mem[tailPtr] <= entryA;
        end
        if (pushB) begin
            mem[pushA ? tailPlusOne : tailPtr] <= entryB;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            tailPtr <= tailPtr + PTRW'(pushCount);
            if (popEff) begin
                headPtr <= headPtr + PTRW'(1);
            end
            count <= count + CNTW'(pushCount) - CNTW'(popEff);
        end
    end

    always_comb begin
        slotValid = '0;
        slotDst   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PTRW-1:0] offset;
            offset       = PTRW'(i) - headPtr;
            slotDst[i]   = mem[i].dst;
            slotValid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// Register-file writer: merges load and ALU results into one write port,
// drops R0 writes, normalises byte modes and flags pending-write hazards.
module rf_writeback_queue
    import rf_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTRW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic [3:0]    mem_dst,
    input  logic [15:0]   mem_data,
    input  logic          alu_valid,
    input  logic [3:0]    alu_dst,
    input  logic [15:0]   alu_data,
    input  logic          alu_llb,
    input  logic          alu_lhb,
    output logic          in_ready,
    input  logic [3:0]    rd_reg1,
    input  logic [3:0]    rd_reg2,
    output logic          hazard1,
    output logic          hazard2,
    output logic [3:0]    DstReg,
    output logic [15:0]   DstData,
    output logic          WriteReg,
    output logic          llb,
    output logic          lhb,
    output logic [PTRW:0] occupancy
);

    localparam int unsigned CNTW = PTRW + 1;

    logic                  memPush;
    logic                  aluPush;
    wbEntry_t              memEntry;
    wbEntry_t              aluEntry;
    wbEntry_t              headEntry;
    wbEntry_t              outEntry;
    logic [PTRW:0]         count;
    logic [DEPTH-1:0]      slotValid;
    logic [DEPTH-1:0][3:0] slotDst;
    byteMode_e             aluMode;

    assign in_ready = (count <= CNTW'(DEPTH - 2));
    assign memPush  = rst && in_ready && mem_valid && (mem_dst != REG_ZERO);
    assign aluPush  = rst && in_ready && alu_valid && (alu_dst != REG_ZERO);

    assign aluMode  = byteModeOf(alu_llb, alu_lhb);
    assign memEntry = '{dst: mem_dst, data: mem_data, llb: 1'b0, lhb: 1'b0};
    assign aluEntry = '{dst: alu_dst, data: alu_data, llb: aluMode[1], lhb: aluMode[0]};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstN     (rst),
        .pushA    (memPush),
        .entryA   (memEntry),
        .pushB    (aluPush),
        .entryB   (aluEntry),
        .pop      (WriteReg),
        .headEntry(headEntry),
        .count    (count),
        .slotValid(slotValid),
        .slotDst  (slotDst)
    );

    assign WriteReg  = (count != '0);
    assign outEntry  = WriteReg ? headEntry : '0;
    assign DstReg    = outEntry.dst;
    assign DstData   = outEntry.data;
    assign llb       = outEntry.llb;
    assign lhb       = outEntry.lhb;
    assign occupancy = count;

    // The head being written this cycle still counts: no write-through.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slotValid[i] && (slotDst[i] == rd_reg1)) hazard1 = 1'b1;
            if (slotValid[i] && (slotDst[i] == rd_reg2)) hazard2 = 1'b1;
        end
        if (memPush && (mem_dst == rd_reg1)) hazard1 = 1'b1;
        if (memPush && (mem_dst == rd_reg2)) hazard2 = 1'b1;
        if (aluPush && (alu_dst == rd_reg1)) hazard1 = 1'b1;
        if (aluPush && (alu_dst == rd_reg2)) hazard2 = 1'b1;
        hazard1 = hazard1 && (rd_reg1 != REG_ZERO);
        hazard2 = hazard2 && (rd_reg2 != REG_ZERO);
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue with DEPTH=4 and hand-computed expectations.
module tb_rf_writeback_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_dst = '0;
    logic [15:0] mem_data = '0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_dst = '0;
    logic [15:0] alu_data = '0;
    logic        alu_llb = 1'b0;
    logic        alu_lhb = 1'b0;
    logic        in_ready;
    logic [3:0]  rd_reg1 = '0;
    logic [3:0]  rd_reg2 = '0;
    logic        hazard1;
    logic        hazard2;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic        WriteReg;
    logic        llb;
    logic        lhb;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    rf_writeback_queue #(
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_dst  (mem_dst),
        .mem_data (mem_data),
        .alu_valid(alu_valid),
        .alu_dst  (alu_dst),
        .alu_data (alu_data),
        .alu_llb  (alu_llb),
        .alu_lhb  (alu_lhb),
        .in_ready (in_ready),
        .rd_reg1  (rd_reg1),
        .rd_reg2  (rd_reg2),
        .hazard1  (hazard1),
        .hazard2  (hazard2),
        .DstReg   (DstReg),
        .DstData  (DstData),
        .WriteReg (WriteReg),
        .llb      (llb),
        .lhb      (lhb),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        mem_valid = 1'b0; mem_dst = '0; mem_data = '0;
        alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
        alu_llb = 1'b0; alu_lhb = 1'b0;
    endtask

    task automatic setMem(input logic [3:0] d, input logic [15:0] v);
        mem_valid = 1'b1; mem_dst = d; mem_data = v;
    endtask

    task automatic setAlu(input logic [3:0] d, input logic [15:0] v, input logic l, input logic h);
        alu_valid = 1'b1; alu_dst = d; alu_data = v; alu_llb = l; alu_lhb = h;
    endtask

    task automatic test_reset();
        rd_reg1 = 4'd7; rd_reg2 = 4'd0;
        #12;
        checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL reset_WriteReg: got %b want 0", WriteReg); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if ({DstReg, DstData, llb, lhb} !== 22'd0) begin errors++; $display("FAIL reset_port: got %h/%h/%b%b want 0", DstReg, DstData, llb, lhb); end
        checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL reset_hazard1: got %b want 0", hazard1); end
        @(posedge clk); #1;
        rst = 1'b1;
        rd_reg1 = 4'd0;
    endtask

    task automatic test_single_alu();
        setAlu(4'd3, 16'hBEEF, 1'b0, 1'b0);
        step();
        clearInputs();
        checks++; if (WriteReg !== 1'b1) begin errors++; $display("FAIL single_WriteReg: got %b want 1", WriteReg); end
        checks++; if (DstReg !== 4'd3) begin errors++; $display("FAIL single_DstReg: got %0d want 3", DstReg); end
        checks++; if (DstData !== 16'hBEEF) begin errors++; $display("FAIL single_DstData: got %h want BEEF", DstData); end
        checks++; if ({llb, lhb} !== 2'b00) begin errors++; $display("FAIL single_bytes: got %b%b want 00", llb, lhb); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ: got %0d want 1", occupancy); end
        step();
        checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", WriteReg); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL single_occ_end: got %0d want 0", occupancy); end
    endtask

    task automatic test_dual_issue();
        setMem(4'd5, 16'h1111);
        setAlu(4'd6, 16'h2222, 1'b0, 1'b0);
        step();
        clearInputs();
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL dual_occ2: got %0d want 2", occupancy); end
        checks++; if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd5, 16'h1111}) begin errors++; $display("FAIL dual_first: got %b/%0d/%h want 1/5/1111", WriteReg, DstReg, DstData); end
        step();
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL dual_occ1: got %0d want 1", occupancy); end
        checks++; if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd6, 16'h2222}) begin errors++; $display("FAIL dual_second: got %b/%0d/%h want 1/6/2222", WriteReg, DstReg, DstData); end
        step();
        checks++; if ({WriteReg, occupancy} !== {1'b0, 3'd0}) begin errors++; $display("FAIL dual_empty: got %b/%0d want 0/0", WriteReg, occupancy); end
    endtask

    task automatic test_backpressure();
        logic [3:0] expDst [6];
        expDst = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b want 1", in_ready); end
        setMem(4'd1, 16'hA001); setAlu(4'd2, 16'hA002, 1'b0, 1'b0);
        step();
        checks++; if ({DstReg, occupancy, in_ready} !== {4'd1, 3'd2, 1'b1}) begin errors++; $display("FAIL bp_e1: got %0d/%0d/%b want 1/2/1", DstReg, occupancy, in_ready); end
        setMem(4'd3, 16'hA003); setAlu(4'd4, 16'hA004, 1'b0, 1'b0);
        step();
        checks++; if ({DstReg, occupancy, in_ready} !== {4'd2, 3'd3, 1'b0}) begin errors++; $display("FAIL bp_e2: got %0d/%0d/%b want 2/3/0", DstReg, occupancy, in_ready); end
        setMem(4'd10, 16'hBAD0); setAlu(4'd11, 16'hBAD1, 1'b0, 1'b0);
        rd_reg1 = 4'd10;
        #1;
        checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL bp_ignored_hazard: got %b want 0", hazard1); end
        rd_reg1 = 4'd0;
        step();
        checks++; if ({DstReg, occupancy, in_ready} !== {4'd3, 3'd2, 1'b1}) begin errors++; $display("FAIL bp_e3: got %0d/%0d/%b want 3/2/1", DstReg, occupancy, in_ready); end
        setMem(4'd8, 16'hA008); setAlu(4'd9, 16'hA009, 1'b0, 1'b0);
        step();
        clearInputs();
        checks++; if ({DstReg, occupancy} !== {4'd4, 3'd3}) begin errors++; $display("FAIL bp_e4: got %0d/%0d want 4/3", DstReg, occupancy); end
        for (int i = 4; i < 6; i++) begin
            step();
            checks++;
            if ({WriteReg, DstReg, DstData} !== {1'b1, expDst[i], 12'hA00, expDst[i]}) begin
                errors++; $display("FAIL bp_order%0d: got %b/%0d/%h want 1/%0d/A00%h", i, WriteReg, DstReg, DstData, expDst[i], expDst[i]);
            end
        end
        step();
        checks++; if ({WriteReg, occupancy} !== {1'b0, 3'd0}) begin errors++; $display("FAIL bp_empty: got %b/%0d want 0/0", WriteReg, occupancy); end
    endtask

    task automatic test_r0_bytes();
        setAlu(4'd0, 16'h1234, 1'b0, 1'b0);
        step();
        clearInputs();
        checks++; if ({WriteReg, occupancy} !== {1'b0, 3'd0}) begin errors++; $display("FAIL r0_dropped: got %b/%0d want 0/0", WriteReg, occupancy); end
        setAlu(4'd2, 16'h00AB, 1'b1, 1'b0);
        step();
        clearInputs();
        checks++; if ({DstReg, DstData, llb, lhb} !== {4'd2, 16'h00AB, 2'b10}) begin errors++; $display("FAIL llb_only: got %0d/%h/%b%b want 2/00AB/10", DstReg, DstData, llb, lhb); end
        step();
        setAlu(4'd2, 16'h00CD, 1'b1, 1'b1);
        step();
        clearInputs();
        checks++; if ({DstData, llb, lhb} !== {16'h00CD, 2'b10}) begin errors++; $display("FAIL llb_lhb_both: got %h/%b%b want 00CD/10", DstData, llb, lhb); end
        step();
        setAlu(4'd4, 16'hEF00, 1'b0, 1'b1);
        setMem(4'd0, 16'h5555);
        step();
        clearInputs();
        checks++; if ({occupancy, DstReg, llb, lhb} !== {3'd1, 4'd4, 2'b01}) begin errors++; $display("FAIL lhb_mem_r0: got %0d/%0d/%b%b want 1/4/01", occupancy, DstReg, llb, lhb); end
        step();
    endtask

    task automatic test_hazard();
        rd_reg1 = 4'd7; rd_reg2 = 4'd0;
        setAlu(4'd7, 16'h7777, 1'b0, 1'b0);
        #1;
        checks++; if ({hazard1, hazard2} !== 2'b10) begin errors++; $display("FAIL haz_input: got %b%b want 10", hazard1, hazard2); end
        step();
        setAlu(4'd0, 16'h0000, 1'b0, 1'b0);
        #1;
        checks++; if ({WriteReg, hazard1, hazard2} !== 3'b110) begin errors++; $display("FAIL haz_head: got %b%b%b want 110", WriteReg, hazard1, hazard2); end
        step();
        clearInputs();
        checks++; if ({WriteReg, hazard1} !== 2'b00) begin errors++; $display("FAIL haz_cleared: got %b%b want 00", WriteReg, hazard1); end
        rd_reg1 = 4'd0; rd_reg2 = 4'd7;
        setMem(4'd5, 16'h0505); setAlu(4'd7, 16'h0707, 1'b0, 1'b0);
        step();
        clearInputs();
        checks++; if ({DstReg, hazard1, hazard2} !== {4'd5, 2'b01}) begin errors++; $display("FAIL haz_slot1: got %0d/%b%b want 5/01", DstReg, hazard1, hazard2); end
        step();
        step();
        checks++; if (hazard2 !== 1'b0) begin errors++; $display("FAIL haz2_cleared: got %b want 0", hazard2); end
        rd_reg2 = 4'd0;
    endtask

    task automatic test_reset_mid_drain();
        setMem(4'd1, 16'hC001); setAlu(4'd2, 16'hC002, 1'b0, 1'b0);
        step();
        setMem(4'd3, 16'hC003); setAlu(4'd4, 16'hC004, 1'b0, 1'b0);
        step();
        clearInputs();
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL rmd_setup: got %0d want 3", occupancy); end
        rd_reg1 = 4'd3;
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({WriteReg, occupancy, in_ready} !== {1'b0, 3'd0, 1'b1}) begin errors++; $display("FAIL rmd_async: got %b/%0d/%b want 0/0/1", WriteReg, occupancy, in_ready); end
        checks++; if ({DstReg, DstData, llb, lhb, hazard1} !== 23'd0) begin errors++; $display("FAIL rmd_port: got %0d/%h/%b%b/%b want 0", DstReg, DstData, llb, lhb, hazard1); end
        step();
        rst = 1'b1;
        #1;
        checks++; if ({WriteReg, occupancy} !== {1'b0, 3'd0}) begin errors++; $display("FAIL rmd_release: got %b/%0d want 0/0", WriteReg, occupancy); end
        step();
        checks++; if ({WriteReg, occupancy, hazard1} !== {1'b0, 3'd0, 1'b0}) begin errors++; $display("FAIL rmd_stale: got %b/%0d/%b want 0/0/0", WriteReg, occupancy, hazard1); end
        rd_reg1 = 4'd0;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_dual_issue();
        test_backpressure();
        test_r0_bytes();
        test_hazard();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
